// File: rtl/layer1_pkg.sv
// Shared definitions for the layer-1 pooling datapath: default sizes and the
// pooling FSM state encoding.
package layer1_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int MAP_W_DEF  = 28;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EVEN_ROW   = 2'd1,
        ODD_ROW    = 2'd2,
        FRAME_DONE = 2'd3
    } pool_state_t;

endpackage

// File: rtl/pool_row_buf.sv
// Half-row buffer holding the horizontal pair maxima of the current even row;
// synchronous write, combinational read.
module pool_row_buf
    import layer1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = MAP_W_DEF / 2,
    parameter int IDX_W  = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/maxpool_layer1.sv
// 2x2 stride-2 signed max-pool over a raster-ordered conv1 feature map.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool_layer1
    import layer1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int MAP_W  = MAP_W_DEF
) (
    input  logic                     pool_clk,
    input  logic                     pool_rst_b,
    input  logic                     load_counters_i,
    input  logic                     lb_pool_cnt_en_i,
    input  logic signed [DATA_W-1:0] conv1_data_i,
    input  logic                     conv1_valid_i,
    output logic signed [DATA_W-1:0] pool_data_o,
    output logic                     pool_valid_o,
    output logic                     pool_row_done_o,
    output logic                     pool_frame_done_o
);

    localparam int CNT_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int IDX_W = (CNT_W > 1) ? CNT_W - 1 : 1;
    localparam int BUF_D = MAP_W / 2;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [DATA_W-1:0] relu_clamp(
        input logic signed [DATA_W-1:0] v
    );
`ifdef MAXPOOL_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    pool_state_t state, state_nxt;
    logic [CNT_W-1:0] col, row;
    logic [IDX_W-1:0] buf_idx;
    logic             accept, col_last, row_last, odd_phase;
    logic             buf_wr_p0, res_vld_p0;
    logic signed [DATA_W-1:0] even_smp_p0, pair_max_p0, buf_rd_p0, win_max_p0;
    logic signed [DATA_W-1:0] data_p1;
    logic                     vld_p1, row_done_p1, frame_done_p1;

    assign accept    = conv1_valid_i & lb_pool_cnt_en_i;
    assign col_last  = (col == CNT_W'(MAP_W - 1));
    assign row_last  = (row == CNT_W'(MAP_W - 1));
    assign odd_phase = (state == ODD_ROW);

    if (CNT_W > 1) begin : g_idx
        assign buf_idx = col[CNT_W-1:1];
    end else begin : g_idx_narrow
        assign buf_idx = '0;
    end

    always_ff @(posedge pool_clk or negedge pool_rst_b) begin
        if (!pool_rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (load_counters_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:       if (lb_pool_cnt_en_i) state_nxt = EVEN_ROW;
                EVEN_ROW:   if (accept && col_last) state_nxt = ODD_ROW;
                ODD_ROW:    if (accept && col_last) state_nxt = row_last ? FRAME_DONE : EVEN_ROW;
                FRAME_DONE: state_nxt = IDLE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge pool_clk or negedge pool_rst_b) begin
        if (!pool_rst_b) begin
            col <= '0;
            row <= '0;
        end else if (load_counters_i) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    // p0: accept stage -- pair max, buffer update, window completion
    always_ff @(posedge pool_clk) begin
        if (accept && !load_counters_i && !col[0]) begin
            even_smp_p0 <= conv1_data_i;
        end
    end

    assign pair_max_p0 = smax(even_smp_p0, conv1_data_i);
    assign win_max_p0  = smax(pair_max_p0, buf_rd_p0);
    // Any non-odd state handles even-row work, so a sample arriving in IDLE is kept.
    assign buf_wr_p0   = accept & ~load_counters_i & ~odd_phase & col[0];
    assign res_vld_p0  = accept & ~load_counters_i &  odd_phase & col[0];

    pool_row_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_D),
        .IDX_W  (IDX_W)
    ) u_row_buf (
        .clk     (pool_clk),
        .wr_en   (buf_wr_p0),
        .wr_idx  (buf_idx),
        .wr_data (pair_max_p0),
        .rd_idx  (buf_idx),
        .rd_data (buf_rd_p0)
    );

    // p1: registered outputs
    always_ff @(posedge pool_clk or negedge pool_rst_b) begin
        if (!pool_rst_b) begin
            data_p1       <= '0;
            vld_p1        <= 1'b0;
            row_done_p1   <= 1'b0;
            frame_done_p1 <= 1'b0;
        end else if (load_counters_i) begin
            data_p1       <= '0;
            vld_p1        <= 1'b0;
            row_done_p1   <= 1'b0;
            frame_done_p1 <= 1'b0;
        end else begin
            vld_p1        <= res_vld_p0;
            row_done_p1   <= res_vld_p0 & col_last;
            frame_done_p1 <= (state == FRAME_DONE);
            if (res_vld_p0) begin
                data_p1 <= relu_clamp(win_max_p0);
            end
        end
    end

    assign pool_data_o       = data_p1;
    assign pool_valid_o      = vld_p1;
    assign pool_row_done_o   = row_done_p1;
    assign pool_frame_done_o = frame_done_p1;

endmodule

// File: tb/tb_maxpool_layer1.sv
// Directed bench for maxpool_layer1: 4x4 table frames, stall/load/reset
// sequences, and one random 28x28 frame against a bench-side reference.
module tb_maxpool_layer1;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b;
    logic load4, en4, vld4;
    logic signed [DW-1:0] din4, d4;
    logic v4, rd4, fd4;
    logic load28, en28, vld28;
    logic signed [DW-1:0] din28, d28;
    logic v28, rd28, fd28;

    maxpool_layer1 #(.DATA_W(DW), .MAP_W(4)) dut4 (
        .pool_clk          (clk),
        .pool_rst_b        (rst_b),
        .load_counters_i   (load4),
        .lb_pool_cnt_en_i  (en4),
        .conv1_data_i      (din4),
        .conv1_valid_i     (vld4),
        .pool_data_o       (d4),
        .pool_valid_o      (v4),
        .pool_row_done_o   (rd4),
        .pool_frame_done_o (fd4)
    );

    maxpool_layer1 #(.DATA_W(DW), .MAP_W(28)) dut28 (
        .pool_clk          (clk),
        .pool_rst_b        (rst_b),
        .load_counters_i   (load28),
        .lb_pool_cnt_en_i  (en28),
        .conv1_data_i      (din28),
        .conv1_valid_i     (vld28),
        .pool_data_o       (d28),
        .pool_valid_o      (v28),
        .pool_row_done_o   (rd28),
        .pool_frame_done_o (fd28)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic int relu_exp(input int v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    typedef struct {
        int din[16];
        int res[4];
    } frame_vec_t;

    frame_vec_t vecs[5];

    // 4x4 output monitor
    int res_q[$];
    bit rd_q[$];
    int cyc = 0;
    int last_vld_cyc, fd_cyc, fd_cnt, dbl_cnt, stray_cnt;
    bit prev_vld = 1'b0;
    bit prev_fd  = 1'b0;

    always @(negedge clk) begin
        if (v4) begin
            res_q.push_back(int'(d4));
            rd_q.push_back(rd4);
            last_vld_cyc = cyc;
            if (prev_vld) dbl_cnt++;
        end else if (rd4) begin
            stray_cnt++;
        end
        if (fd4) begin
            fd_cnt++;
            fd_cyc = cyc;
            if (prev_fd) dbl_cnt++;
        end
        prev_vld = v4;
        prev_fd  = fd4;
        cyc++;
    end

    // 28x28 output monitor
    int res28_q[$];
    bit rd28_q[$];
    int fd28_cnt = 0;
    int stray28 = 0;

    always @(negedge clk) begin
        if (v28) begin
            res28_q.push_back(int'(d28));
            rd28_q.push_back(rd28);
        end else if (rd28) begin
            stray28++;
        end
        if (fd28) fd28_cnt++;
    end

    task automatic clear_mon();
        res_q.delete();
        rd_q.delete();
        fd_cnt = 0;
        dbl_cnt = 0;
        stray_cnt = 0;
        fd_cyc = -1;
        last_vld_cyc = -100;
    endtask

    task automatic feed4(input int d);
        @(posedge clk);
        #1;
        din4 = DW'(d);
        vld4 = 1'b1;
        en4  = 1'b1;
    endtask

    task automatic drain4();
        @(posedge clk);
        #1;
        vld4 = 1'b0;
        din4 = DW'(999);
        repeat (6) @(posedge clk);
    endtask

    task automatic feed_frame(input int k, input bit chk_lat);
        for (int i = 0; i < 16; i++) begin
            feed4(vecs[k].din[i]);
            if (chk_lat && i == 6) begin
                @(negedge clk);
                check("latency valid", int'(v4), 1);
                check("latency data", int'(d4), relu_exp(vecs[k].res[0]));
            end
        end
        drain4();
    endtask

    task automatic check_frame(input string nm, input int k);
        int act;
        check($sformatf("%s count", nm), res_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            act = (i < res_q.size()) ? res_q[i] : -99999;
            check($sformatf("%s res%0d", nm, i), act, relu_exp(vecs[k].res[i]));
            act = (i < rd_q.size()) ? int'(rd_q[i]) : -1;
            check($sformatf("%s row_done%0d", nm, i), act, i % 2);
        end
        check($sformatf("%s frame_done count", nm), fd_cnt, 1);
        check($sformatf("%s frame_done cycle", nm), fd_cyc, last_vld_cyc + 1);
        check($sformatf("%s double pulse", nm), dbl_cnt, 0);
        check($sformatf("%s stray row_done", nm), stray_cnt, 0);
    endtask

    int frame28[784];
    int exp28[196];

    initial begin
        vecs[0].din = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
        vecs[0].res = '{5, 7, 13, 15};
        vecs[1].din = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        vecs[1].res = '{15, 13, 7, 5};
        vecs[2].din = '{-3, -8, -20, -7, -1, -5, -9, -30, 4, -2, -6, -6, 0, -4, -6, -6};
        vecs[2].res = '{-1, -7, 4, -6};
        vecs[3].din = '{-32768, 32767, 0, 0, -32768, -32768, 1, -1, 7, 7, 7, 7, 7, 7, 7, 7};
        vecs[3].res = '{32767, 1, 7, 7};
        vecs[4].din = '{1, 2, 3, 9, 8, 4, 5, 6, -1, -1, -9, -2, -1, -1, -3, -8};
        vecs[4].res = '{8, 9, -1, -2};

        rst_b = 1'b0;
        load4 = 1'b0; en4 = 1'b0; vld4 = 1'b0; din4 = '0;
        load28 = 1'b0; en28 = 1'b0; vld28 = 1'b0; din28 = '0;
        clear_mon();

        repeat (2) @(negedge clk);
        check("reset data", int'(d4), 0);
        check("reset valid", int'(v4), 0);
        check("reset row_done", int'(rd4), 0);
        check("reset frame_done", int'(fd4), 0);
        check("reset valid 28", int'(v28), 0);
        rst_b = 1'b1;

        for (int k = 0; k < 5; k++) begin
            clear_mon();
            feed_frame(k, k == 2);
            check_frame($sformatf("table%0d", k), k);
        end

        // gapped valid plus a five-cycle enable drop mid-row
        clear_mon();
        for (int i = 0; i < 16; i++) begin
            feed4(vecs[0].din[i]);
            @(posedge clk);
            #1;
            vld4 = 1'b0;
            din4 = DW'(999);
            if (i == 6) begin
                en4  = 1'b0;
                vld4 = 1'b1;
                din4 = DW'(77);
                repeat (5) @(posedge clk);
                #1;
                vld4 = 1'b0;
            end
        end
        drain4();
        check_frame("stall", 0);

        // synchronous load at row 2 col 1 together with an accept
        clear_mon();
        for (int i = 0; i < 9; i++) feed4(vecs[0].din[i]);
        @(posedge clk);
        #1;
        din4  = DW'(9);
        vld4  = 1'b1;
        load4 = 1'b1;
        @(posedge clk);
        #1;
        load4 = 1'b0;
        vld4  = 1'b0;
        @(negedge clk);
        check("load data cleared", int'(d4), 0);
        check("load valid cleared", int'(v4), 0);
        check("load results before", res_q.size(), 2);
        clear_mon();
        repeat (8) @(posedge clk);
        check("load no further valids", res_q.size(), 0);
        check("load no frame_done", fd_cnt, 0);
        clear_mon();
        feed_frame(4, 1'b0);
        check_frame("after load", 4);

        // asynchronous reset while in an odd row
        clear_mon();
        for (int i = 0; i < 6; i++) feed4(vecs[0].din[i]);
        @(posedge clk);
        #1;
        vld4 = 1'b0;
        #2;
        rst_b = 1'b0;
        #1;
        check("midreset data", int'(d4), 0);
        check("midreset valid", int'(v4), 0);
        check("midreset row_done", int'(rd4), 0);
        check("midreset frame_done", int'(fd4), 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        clear_mon();
        feed_frame(1, 1'b0);
        check_frame("after reset", 1);

        // random 28x28 frame against a bench-side 2x2 max reference
        for (int i = 0; i < 784; i++) frame28[i] = int'($urandom_range(0, 65535)) - 32768;
        for (int r = 0; r < 14; r++) begin
            for (int c = 0; c < 14; c++) begin
                int m;
                m = frame28[(2 * r) * 28 + 2 * c];
                if (frame28[(2 * r) * 28 + 2 * c + 1] > m) m = frame28[(2 * r) * 28 + 2 * c + 1];
                if (frame28[(2 * r + 1) * 28 + 2 * c] > m) m = frame28[(2 * r + 1) * 28 + 2 * c];
                if (frame28[(2 * r + 1) * 28 + 2 * c + 1] > m) m = frame28[(2 * r + 1) * 28 + 2 * c + 1];
                exp28[r * 14 + c] = relu_exp(m);
            end
        end
        res28_q.delete();
        rd28_q.delete();
        fd28_cnt = 0;
        stray28 = 0;
        for (int i = 0; i < 784; i++) begin
            @(posedge clk);
            #1;
            din28 = DW'(frame28[i]);
            vld28 = 1'b1;
            en28  = 1'b1;
        end
        @(posedge clk);
        #1;
        vld28 = 1'b0;
        repeat (6) @(posedge clk);
        check("map28 count", res28_q.size(), 196);
        begin
            int rd_total;
            int act;
            rd_total = 0;
            for (int i = 0; i < 196; i++) begin
                act = (i < res28_q.size()) ? res28_q[i] : -99999;
                check($sformatf("map28 res%0d", i), act, exp28[i]);
                act = (i < rd28_q.size()) ? int'(rd28_q[i]) : -1;
                check($sformatf("map28 row_done%0d", i), act, (i % 14 == 13) ? 1 : 0);
                if (act == 1) rd_total++;
            end
            check("map28 row_done total", rd_total, 14);
        end
        check("map28 frame_done count", fd28_cnt, 1);
        check("map28 stray row_done", stray28, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/maxpool_layer1.md
MAXPOOL_LAYER1 -- requirements
Module: maxpool_layer1

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed conv1 sample width.
REQ-002 SHALL have parameter MAP_W, default 28, conv1 feature-map width and height in samples; must be even.
REQ-003 SHALL have port pool_clk  input  1  the single clock.
REQ-004 SHALL have port pool_rst_b  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port load_counters_i  input  1  synchronous clear of counters and state.
REQ-006 SHALL have port lb_pool_cnt_en_i  input  1  enables pool buffer load and counting.
REQ-007 SHALL have port conv1_data_i  input  DATA_W  signed conv1 output sample.
REQ-008 SHALL have port conv1_valid_i  input  1  conv1_data_i valid this cycle.
REQ-009 SHALL have port pool_data_o  output  DATA_W  signed 2x2 max-pool result.
REQ-010 SHALL have port pool_valid_o  output  1  pool_data_o valid, one-cycle pulse per result.
REQ-011 SHALL have port pool_row_done_o  output  1  pulse with last result of a pooled row.
REQ-012 SHALL have port pool_frame_done_o  output  1  pulse one cycle after last result of frame.

Function
REQ-013 SHALL accept a sample only when conv1_valid_i and lb_pool_cnt_en_i are both 1 (an "accept"); samples arrive raster order, row-major.
REQ-014 SHALL keep col counter 0..MAP_W-1 and row counter 0..MAP_W-1, advancing on accept; col wraps to 0 and row increments at col MAP_W-1.
REQ-015 SHALL implement FSM states IDLE, EVEN_ROW, ODD_ROW, FRAME_DONE.
REQ-016 SHALL transition IDLE->EVEN_ROW when lb_pool_cnt_en_i=1; EVEN_ROW->ODD_ROW on accept at col MAP_W-1; ODD_ROW->EVEN_ROW on accept at col MAP_W-1 if row<MAP_W-1, else ->FRAME_DONE; FRAME_DONE->IDLE unconditionally next cycle.
REQ-017 SHALL, in EVEN_ROW, hold the even-col sample and on the odd-col accept write signed max of the pair into row buffer entry col/2 (MAP_W/2 entries).
REQ-018 SHALL, in ODD_ROW, on odd-col accept compute signed max of the pair and buffer entry col/2, registering it to pool_data_o with pool_valid_o=1 the next cycle (latency 1 from the completing accept).
REQ-019 SHALL assert pool_row_done_o coincident with pool_valid_o for buffer entry MAP_W/2-1.
REQ-020 SHALL assert pool_frame_done_o for exactly the FRAME_DONE cycle; produces (MAP_W/2)^2 results per frame.
REQ-021 SHALL, when lb_pool_cnt_en_i drops mid-frame, freeze counters, state and buffer; resume on re-assert with no lost or duplicated result.
REQ-022 SHALL compare signed; equal inputs yield that value; no width growth.
REQ-023 SHALL give load_counters_i priority over accept: same cycle, sample discarded, state->IDLE, counters 0, outputs 0 next cycle; buffer contents need not be cleared.

Reset
REQ-024 SHALL on pool_rst_b=0 asynchronously set state IDLE, counters 0, pool_data_o 0, pool_valid_o 0, pool_row_done_o 0, pool_frame_done_o 0.
REQ-025 SHALL discard any partial frame on reset mid-operation; first frame after release starts at row 0 col 0.

Configuration
REQ-026 SHALL, with macro MAXPOOL_RELU_EN defined, clamp pool_data_o to 0 when the pooled max is negative; without it, pass the signed max unchanged.

Structure
REQ-027 SHALL take FSM state enum, DATA_W and MAP_W defaults from shared package layer1_pkg.
REQ-028 SHALL place the MAP_W/2-entry row buffer in sub-module pool_row_buf (synchronous write, combinational read by index).

Verification
REQ-029 4x4 frame (MAP_W=4) values 0..15 row-major, en=1 -> results 5,7,13,15; row_done with 7 and 15; frame_done one cycle after 15.
REQ-030 2x2 window {-3,-8,-1,-5} -> 1 cycle after last accept pool_data_o=-1 without MAXPOOL_RELU_EN; 0 with it.
REQ-031 conv1_valid_i toggling 1/0 and en dropped 5 cycles mid-row -> results identical to continuous feed, each pulse single-cycle.
REQ-032 load_counters_i asserted at row 2 col 1 with accept -> no further valids; new frame then yields correct 4 results.
REQ-033 pool_rst_b low during ODD_ROW -> all outputs 0 immediately; following full frame correct.
REQ-034 MAP_W=28 full random frame -> 196 results matching reference model, 14 row_done pulses, 1 frame_done.
